// File: rtl/pad_input_cond.sv
// pad_input_cond: input-side conditioning for the IO pad ring.
// Each pad is synchronised into the core clock domain and presented raw on
// fn_i. A per-pin optionally debounced copy is registered onto gpio_i, and
// sticky rising/falling edge flags derived from gpio_i drive irq_pending/irq.
module pad_input_cond #(
    parameter int unsigned WIDTH       = 20,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_TICKS    = 4,
    parameter int unsigned DIV_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pad_i,
    input  logic [WIDTH-1:0] debounce_en,
    input  logic [DIV_W-1:0] debounce_div,
    input  logic [WIDTH-1:0] irq_rise_en,
    input  logic [WIDTH-1:0] irq_fall_en,
    input  logic [WIDTH-1:0] irq_clr,
    output logic [WIDTH-1:0] fn_i,
    output logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] irq_pending,
    output logic             irq
);

    // Debounce counter only has to reach DB_TICKS-1 before it is reloaded.
    localparam int unsigned DCW = $clog2(DB_TICKS + 1);
    localparam logic [DCW-1:0] DC_LAST = DCW'(DB_TICKS - 1);

    // Synchroniser chain, stage 0 samples the pad.
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;

    // Shared debounce prescaler.
    logic [DIV_W-1:0] pc_q;
    logic [DIV_W-1:0] pc_d;
    logic             tick;

    // Per-pin debounce state.
    logic [DCW-1:0]   dc_q [WIDTH];
    logic [DCW-1:0]   dc_d [WIDTH];
    logic [WIDTH-1:0] gpio_q;
    logic [WIDTH-1:0] gpio_d;

    // Edge detection and sticky flags.
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] pend_d;

    // Shift each pad through SYNC_STAGES flops to resolve metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pad_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Free-running prescaler; >= so lowering the divider below pc ticks at once.
    always_comb begin
        tick = (pc_q >= debounce_div);
        pc_d = tick ? '0 : pc_q + DIV_W'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Per-pin debounce: any tick seen with s matching gpio restarts the count,
    // so a glitch shorter than DB_TICKS ticks leaves no trace.
    always_comb begin
        gpio_d = gpio_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            dc_d[i] = dc_q[i];
            if (!debounce_en[i]) begin
                gpio_d[i] = s[i];
                dc_d[i]   = '0;
            end else if (s[i] == gpio_q[i]) begin
                dc_d[i] = '0;
            end else if (tick) begin
                if (dc_q[i] == DC_LAST) begin
                    gpio_d[i] = s[i];
                    dc_d[i]   = '0;
                end else begin
                    dc_d[i] = dc_q[i] + DCW'(1);
                end
            end
        end
    end

    // Debounce counters and the registered GPIO view.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                dc_q[i] <= '0;
            end
        end else begin
            gpio_q <= gpio_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                dc_q[i] <= dc_d[i];
            end
        end
    end

    // Edge terms and pending update; a set in the same cycle as a clear wins.
    always_comb begin
        rise   = gpio_q & ~prev_q;
        fall   = ~gpio_q & prev_q;
        pend_d = (pend_q & ~irq_clr) | (rise & irq_rise_en) | (fall & irq_fall_en);
    end

    // Previous-value and sticky pending registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= gpio_q;
            pend_q <= pend_d;
        end
    end

    assign fn_i        = s;
    assign gpio_i      = gpio_q;
    assign irq_pending = pend_q;
    assign irq         = |pend_q;

endmodule

// File: tb/tb_pad_input_cond.sv
// Directed bench for pad_input_cond: a vector table for the pass-through and
// interrupt behaviour plus hand sequences for reset and debounce timing.
module tb_pad_input_cond;

    localparam logic [19:0] Z   = 20'h00000;
    localparam logic [19:0] ALL = 20'hFFFFF;
    localparam logic [19:0] P0  = 20'h00001;
    localparam logic [19:0] P5  = 20'h00020;
    localparam logic [19:0] P7  = 20'h00080;

    logic        clk;
    logic        rst;
    logic [19:0] pad_i;
    logic [19:0] debounce_en;
    logic [15:0] debounce_div;
    logic [19:0] irq_rise_en;
    logic [19:0] irq_fall_en;
    logic [19:0] irq_clr;
    logic [19:0] fn_i;
    logic [19:0] gpio_i;
    logic [19:0] irq_pending;
    logic        irq;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [19:0] pad;
        logic [19:0] rise;
        logic [19:0] fall;
        logic [19:0] clr;
        logic [19:0] fn;
        logic [19:0] gpio;
        logic [19:0] pend;
    } vec_t;

    vec_t tbl [17];

    pad_input_cond #(
        .WIDTH(20),
        .SYNC_STAGES(2),
        .DB_TICKS(4),
        .DIV_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pad_i(pad_i),
        .debounce_en(debounce_en),
        .debounce_div(debounce_div),
        .irq_rise_en(irq_rise_en),
        .irq_fall_en(irq_fall_en),
        .irq_clr(irq_clr),
        .fn_i(fn_i),
        .gpio_i(gpio_i),
        .irq_pending(irq_pending),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int lat;
        n_cmp = 0;
        n_err = 0;

        tbl[0]  = '{P5,    Z, Z,  Z,  Z,      Z,      Z};
        tbl[1]  = '{P5,    Z, Z,  Z,  P5,     Z,      Z};
        tbl[2]  = '{P5,    Z, Z,  Z,  P5,     P5,     Z};
        tbl[3]  = '{P5|P7, Z, P7, Z,  P5,     P5,     Z};
        tbl[4]  = '{P5,    Z, P7, Z,  P5|P7,  P5,     Z};
        tbl[5]  = '{P5,    Z, P7, Z,  P5,     P5|P7,  Z};
        tbl[6]  = '{P5,    Z, P7, Z,  P5,     P5,     Z};
        tbl[7]  = '{P5,    Z, P7, Z,  P5,     P5,     P7};
        tbl[8]  = '{P5,    Z, Z,  Z,  P5,     P5,     P7};
        tbl[9]  = '{P5|P7, Z, P7, Z,  P5,     P5,     P7};
        tbl[10] = '{P5,    Z, P7, Z,  P5|P7,  P5,     P7};
        tbl[11] = '{P5,    Z, P7, Z,  P5,     P5|P7,  P7};
        tbl[12] = '{P5,    Z, P7, Z,  P5,     P5,     P7};
        tbl[13] = '{P5,    Z, P7, P7, P5,     P5,     P7};
        tbl[14] = '{P5,    Z, P7, Z,  P5,     P5,     P7};
        tbl[15] = '{P5,    Z, P7, P7, P5,     P5,     Z};
        tbl[16] = '{P5,    Z, P7, Z,  P5,     P5,     Z};

        rst          = 1'b1;
        pad_i        = Z;
        debounce_en  = Z;
        debounce_div = 16'd0;
        irq_rise_en  = Z;
        irq_fall_en  = Z;
        irq_clr      = Z;
        step();
        step();
        rst = 1'b0;

        // Run with all pads high, then reset asynchronously mid-cycle.
        pad_i       = ALL;
        irq_rise_en = ALL;
        for (int i = 0; i < 6; i++) step();
        check("warm_pend", irq_pending, ALL);
        #2;
        rst = 1'b1;
        #1;
        check("rst_fn", fn_i, Z);
        check("rst_gpio", gpio_i, Z);
        check("rst_pend", irq_pending, Z);
        check("rst_irq", irq, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        check("rel_c1_fn", fn_i, Z);
        step();
        check("rel_c2_fn", fn_i, ALL);
        check("rel_c2_gpio", gpio_i, Z);
        step();
        check("rel_c3_gpio", gpio_i, ALL);
        check("rel_c3_pend", irq_pending, Z);
        step();
        check("rel_c4_pend", irq_pending, ALL);
        check("rel_c4_irq", irq, 1'b1);

        // Return to a quiet all-zero state.
        irq_rise_en = Z;
        pad_i       = Z;
        for (int i = 0; i < 5; i++) step();
        irq_clr = ALL;
        step();
        irq_clr = Z;
        check("quiet_irq", irq, 1'b0);
        check("quiet_gpio", gpio_i, Z);

        // Table: pass-through latency, fall-only enable, sticky flag, collision.
        for (int i = 0; i < 17; i++) begin
            pad_i       = tbl[i].pad;
            irq_rise_en = tbl[i].rise;
            irq_fall_en = tbl[i].fall;
            irq_clr     = tbl[i].clr;
            step();
            check($sformatf("tbl%0d_fn", i), fn_i, tbl[i].fn);
            check($sformatf("tbl%0d_gpio", i), gpio_i, tbl[i].gpio);
            check($sformatf("tbl%0d_pend", i), irq_pending, tbl[i].pend);
            check($sformatf("tbl%0d_irq", i), irq, |tbl[i].pend);
        end
        irq_clr     = Z;
        irq_fall_en = Z;

        // Debounce, tick every cycle: 3-cycle glitch rejected.
        debounce_en = P0;
        irq_rise_en = P0;
        for (int i = 0; i < 15; i++) begin
            pad_i = (i < 3) ? (P5 | P0) : P5;
            step();
            check($sformatf("db_glitch_c%0d", i), gpio_i, P5);
        end
        check("db_glitch_pend", irq_pending, Z);

        // Steady high: gpio after 6 cycles, flag one cycle later.
        pad_i = P5 | P0;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (gpio_i[0]) begin
                lat = i;
                break;
            end
        end
        check("db_latency", lat, 6);
        step();
        check("db_pend", irq_pending, P0);
        check("db_irq", irq, 1'b1);
        irq_clr = P0;
        step();
        irq_clr     = Z;
        irq_rise_en = Z;
        check("db_clr", irq_pending, Z);

        // Drop pin 0 with debounce off.
        debounce_en = Z;
        pad_i       = P5;
        for (int i = 0; i < 4; i++) step();
        check("db_off_low", gpio_i, P5);

        // Prescaled debounce, divider 9.
        debounce_en  = P0;
        debounce_div = 16'd9;
        pad_i        = P5 | P0;
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (fn_i[0]) begin
                lat = i;
                break;
            end
        end
        check("pre_fn_lat", lat, 2);
        lat = 999;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (gpio_i[0]) begin
                lat = i;
                break;
            end
        end
        check("pre_lat_ge31", (lat >= 31) ? 1 : 0, 1);
        check("pre_lat_le40", (lat <= 40) ? 1 : 0, 1);

        // 15-cycle low glitch must be rejected.
        for (int i = 0; i < 60; i++) begin
            pad_i = (i < 15) ? P5 : (P5 | P0);
            step();
            check($sformatf("pre_glitch_c%0d", i), gpio_i, P5 | P0);
        end
        check("pre_glitch_pend", irq_pending, Z);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
